// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: free-running h/v counters, registered
// decode, and a configurable delay line that aligns sync/video with pipelined pixel data.
module vga_timing_gen #(
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int H_ACTIVE   = 640,
    parameter int H_FRONT    = 16,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int V_ACTIVE   = 480,
    parameter int V_FRONT    = 10,
    parameter int H_SYNC_POL = 0,
    parameter int V_SYNC_POL = 0,
    parameter int X_WIDTH    = 10,
    parameter int Y_WIDTH    = 10,
    parameter int PIPE_DELAY = 0
) (
    input  logic               clock_25mhz,
    input  logic               reset,
    input  logic               enable,
    output logic               h_sync,
    output logic               v_sync,
    output logic               inside_video,
    output logic [X_WIDTH-1:0] x_position,
    output logic [Y_WIDTH-1:0] y_position,
    output logic               line_start,
    output logic               frame_start
);

    localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
    localparam logic [31:0]   H_SYNC_U  = 32'(H_SYNC);
    localparam logic [31:0]   V_SYNC_U  = 32'(V_SYNC);
    localparam logic [31:0]   H_START_U = 32'(H_SYNC + H_BACK);
    localparam logic [31:0]   V_START_U = 32'(V_SYNC + V_BACK);
    localparam logic [31:0]   H_END_U   = 32'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [31:0]   V_END_U   = 32'(V_SYNC + V_BACK + V_ACTIVE);
    localparam logic          HS_ON     = (H_SYNC_POL != 0);
    localparam logic          VS_ON     = (V_SYNC_POL != 0);

    // Delay-line word: [4]=frame_start [3]=line_start [2]=video [1]=v_sync level [0]=h_sync level
    localparam logic [4:0] PIPE_IDLE = {1'b0, 1'b0, 1'b0, ~VS_ON, ~HS_ON};

    if (PIPE_DELAY > 7 || PIPE_DELAY < 0) begin : g_bad_delay
        $error("vga_timing_gen: PIPE_DELAY must be 0..7");
    end
    if (H_ACTIVE > (1 << X_WIDTH) || V_ACTIVE > (1 << Y_WIDTH)) begin : g_bad_width
        $error("vga_timing_gen: active area does not fit coordinate width");
    end

    logic [HW-1:0]      h_counter_r;
    logic [VW-1:0]      v_counter_r;
    logic [31:0]        h_ext_s;
    logic [31:0]        v_ext_s;
    logic               vid_s;
    logic [4:0]         decode_s;
    logic [X_WIDTH-1:0] x_s;
    logic [Y_WIDTH-1:0] y_s;
    logic [X_WIDTH-1:0] x_r;
    logic [Y_WIDTH-1:0] y_r;
    logic [4:0]         pipe_r [0:PIPE_DELAY];

    // Raster counters; the vertical count steps on the same edge the line wraps.
    always_ff @(posedge clock_25mhz or posedge reset) begin
        if (reset) begin
            h_counter_r <= {HW{1'b0}};
            v_counter_r <= {VW{1'b0}};
        end else if (enable) begin
            if (h_counter_r == H_LAST) begin
                h_counter_r <= {HW{1'b0}};
                if (v_counter_r == V_LAST) begin
                    v_counter_r <= {VW{1'b0}};
                end else begin
                    v_counter_r <= v_counter_r + VW'(1);
                end
            end else begin
                h_counter_r <= h_counter_r + HW'(1);
            end
        end else begin
            h_counter_r <= h_counter_r;
            v_counter_r <= v_counter_r;
        end
    end

    // Stage-0 decode of the current counter values.
    always_comb begin
        h_ext_s  = 32'(h_counter_r);
        v_ext_s  = 32'(v_counter_r);
        vid_s    = (h_ext_s >= H_START_U) && (h_ext_s < H_END_U) &&
                   (v_ext_s >= V_START_U) && (v_ext_s < V_END_U);
        decode_s = PIPE_IDLE;
        decode_s[0] = (h_ext_s < H_SYNC_U) ? HS_ON : ~HS_ON;
        decode_s[1] = (v_ext_s < V_SYNC_U) ? VS_ON : ~VS_ON;
        decode_s[2] = vid_s;
        decode_s[3] = (h_ext_s == 32'd0);
        decode_s[4] = (h_ext_s == 32'd0) && (v_ext_s == 32'd0);
        if (vid_s) begin
            x_s = X_WIDTH'(h_ext_s - H_START_U);
            y_s = Y_WIDTH'(v_ext_s - V_START_U);
        end else begin
            x_s = {X_WIDTH{1'b0}};
            y_s = {Y_WIDTH{1'b0}};
        end
    end

    // Coordinate registers plus the stage-0 word and its delay stages.
    always_ff @(posedge clock_25mhz or posedge reset) begin
        if (reset) begin
            x_r <= {X_WIDTH{1'b0}};
            y_r <= {Y_WIDTH{1'b0}};
            for (int i = 0; i <= PIPE_DELAY; i++) begin
                pipe_r[i] <= PIPE_IDLE;
            end
        end else if (enable) begin
            x_r       <= x_s;
            y_r       <= y_s;
            pipe_r[0] <= decode_s;
            for (int i = 1; i <= PIPE_DELAY; i++) begin
                pipe_r[i] <= pipe_r[i-1];
            end
        end else begin
            x_r <= x_r;
            y_r <= y_r;
        end
    end

    assign x_position   = x_r;
    assign y_position   = y_r;
    assign h_sync       = pipe_r[PIPE_DELAY][0];
    assign v_sync       = pipe_r[PIPE_DELAY][1];
    assign inside_video = pipe_r[PIPE_DELAY][2];
    assign line_start   = pipe_r[PIPE_DELAY][3];
    assign frame_start  = pipe_r[PIPE_DELAY][4];

endmodule
